// File: rtl/fp_multi_sum_pipe.sv
// N-operand floating-point summation pipeline: align, shift, signed sum,
// normalise, then round/saturate, all stalled together by output backpressure.
module fp_multi_sum_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 5,
  parameter int N_IN   = 4,
  parameter int GUARD  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_IN*(1+EXP_W+FRAC_W)-1:0]   in_data,
  input  logic                               rnd_mode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [EXP_W+FRAC_W:0]              out_data,
  output logic                               out_ovf,
  output logic                               out_unf
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1 + GUARD;
  localparam int AW = MW + 1;
  localparam int SW = MW + 1 + $clog2(N_IN) + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX      = EW'((1 << EXP_W) - 2);
  localparam logic signed [EW-1:0] EONE      = EW'(1);
  localparam logic [EXP_W-1:0]     EXP_MAX_F = EXP_W'((1 << EXP_W) - 2);

  logic stall, adv;

  logic                    vld_p1_d, vld_p1_q, rnd_p1_d, rnd_p1_q;
  logic [EXP_W-1:0]        maxexp_p1_d, maxexp_p1_q;
  logic [EXP_W-1:0]        diff_p1_d [N_IN];
  logic [EXP_W-1:0]        diff_p1_q [N_IN];
  logic [MW-1:0]           mant_p1_d [N_IN];
  logic [MW-1:0]           mant_p1_q [N_IN];
  logic [N_IN-1:0]         sgn_p1_d, sgn_p1_q;
  logic [EXP_W-1:0]        op_exp [N_IN];

  logic                    vld_p2_d, vld_p2_q, rnd_p2_d, rnd_p2_q;
  logic [EXP_W-1:0]        maxexp_p2_d, maxexp_p2_q;
  logic [AW-1:0]           aln_p2_d [N_IN];
  logic [AW-1:0]           aln_p2_q [N_IN];
  logic [N_IN-1:0]         sgn_p2_d, sgn_p2_q;
  int                      sh;
  logic [2*MW-1:0]         wide;

  logic                    vld_p3_d, vld_p3_q, rnd_p3_d, rnd_p3_q;
  logic [EXP_W-1:0]        maxexp_p3_d, maxexp_p3_q;
  logic                    rsgn_p3_d, rsgn_p3_q;
  logic [SW-1:0]           mag_p3_d, mag_p3_q;
  logic signed [SW-1:0]    sum, term;

  logic                    vld_p4_d, vld_p4_q, rnd_p4_d, rnd_p4_q;
  logic                    rsgn_p4_d, rsgn_p4_q, zero_p4_d, zero_p4_q;
  logic [AW-1:0]           norm_p4_d, norm_p4_q;
  logic signed [EW-1:0]    exp_p4_d, exp_p4_q;
  int                      lead;
  logic                    stk;

  logic                    out_valid_d, out_valid_q, out_ovf_d, out_ovf_q, out_unf_d, out_unf_q;
  logic [W-1:0]            out_data_d, out_data_q;
  logic [W+1:0]            res_p5;

  // Returns {ovf, unf, data}. nrm holds hidden bit at MW, fraction, guard bits, sticky at 0.
  function automatic logic [W+1:0] round_sat(input logic sgn, input logic [AW-1:0] nrm,
                                             input logic signed [EW-1:0] e, input logic rnd,
                                             input logic zero);
    logic [FRAC_W+1:0]    m;
    logic signed [EW-1:0] ex;
    logic                 inc;
    logic [W+1:0]         r;
    inc = rnd & nrm[GUARD] & ((|nrm[GUARD-1:0]) | nrm[GUARD+1]);
    m   = {1'b0, nrm[MW:GUARD+1]} + (FRAC_W+2)'(inc);
    ex  = m[FRAC_W+1] ? e + EONE : e;
    if (zero)            r = '0;
    else if (ex > EMAX)  r = {1'b1, 1'b0, sgn, EXP_MAX_F, {FRAC_W{1'b1}}};
    else if (ex < EONE)  r = {1'b0, 1'b1, {W{1'b0}}};
    else                 r = {2'b00, sgn, ex[EXP_W-1:0], m[FRAC_W-1:0]};
    return r;
  endfunction

  assign stall     = out_valid_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  // Stage 1: max exponent, per-operand distance and mantissa with hidden bit
  always_comb begin
    vld_p1_d    = in_valid;
    rnd_p1_d    = rnd_mode;
    maxexp_p1_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      op_exp[i] = in_data[i*W+FRAC_W +: EXP_W];
      if (op_exp[i] > maxexp_p1_d) maxexp_p1_d = op_exp[i];
    end
    for (int i = 0; i < N_IN; i++) begin
      sgn_p1_d[i]  = in_data[i*W+W-1];
      diff_p1_d[i] = maxexp_p1_d - op_exp[i];
      mant_p1_d[i] = (op_exp[i] == '0) ? '0 : {1'b1, in_data[i*W +: FRAC_W], {GUARD{1'b0}}};
    end
  end

  // Stage 2: alignment shift, lost bits collapse into a sticky LSB
  always_comb begin
    vld_p2_d    = vld_p1_q;
    rnd_p2_d    = rnd_p1_q;
    maxexp_p2_d = maxexp_p1_q;
    sgn_p2_d    = sgn_p1_q;
    sh          = 0;
    wide        = '0;
    for (int i = 0; i < N_IN; i++) begin
      sh = int'(diff_p1_q[i]);
      if (sh > MW) sh = MW;
      wide        = {mant_p1_q[i], {MW{1'b0}}} >> sh;
      aln_p2_d[i] = {wide[2*MW-1:MW], |wide[MW-1:0]};
    end
  end

  // Stage 3: two's-complement sum, split into sign and magnitude
  always_comb begin
    vld_p3_d    = vld_p2_q;
    rnd_p3_d    = rnd_p2_q;
    maxexp_p3_d = maxexp_p2_q;
    sum         = '0;
    term        = '0;
    for (int i = 0; i < N_IN; i++) begin
      term = $signed({{(SW-AW){1'b0}}, aln_p2_q[i]});
      sum  = sgn_p2_q[i] ? sum - term : sum + term;
    end
    rsgn_p3_d = sum[SW-1];
    mag_p3_d  = rsgn_p3_d ? -sum : sum;
  end

  // Stage 4: leading-one normalise so the hidden bit sits at MW
  always_comb begin
    vld_p4_d  = vld_p3_q;
    rnd_p4_d  = rnd_p3_q;
    rsgn_p4_d = rsgn_p3_q;
    zero_p4_d = ~|mag_p3_q;
    lead      = 0;
    stk       = 1'b0;
    for (int b = 0; b < SW; b++) if (mag_p3_q[b]) lead = b;
    if (lead >= MW) begin
      stk       = |(mag_p3_q << (SW - lead + MW));
      norm_p4_d = AW'(mag_p3_q >> (lead - MW)) | AW'(stk);
    end else begin
      norm_p4_d = AW'(mag_p3_q << (MW - lead));
    end
    exp_p4_d = EW'(int'(maxexp_p3_q) + lead - MW);
  end

  // Stage 5: rounding and saturation into the output register
  always_comb begin
    out_valid_d = vld_p4_q;
    res_p5      = round_sat(rsgn_p4_q, norm_p4_q, exp_p4_q, rnd_p4_q, zero_p4_q);
    out_data_d  = res_p5[W-1:0];
    out_unf_d   = res_p5[W];
    out_ovf_d   = res_p5[W+1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      vld_p4_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (adv) begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      vld_p3_q    <= vld_p3_d;
      vld_p4_q    <= vld_p4_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      rnd_p1_q    <= rnd_p1_d;
      maxexp_p1_q <= maxexp_p1_d;
      diff_p1_q   <= diff_p1_d;
      mant_p1_q   <= mant_p1_d;
      sgn_p1_q    <= sgn_p1_d;
      rnd_p2_q    <= rnd_p2_d;
      maxexp_p2_q <= maxexp_p2_d;
      aln_p2_q    <= aln_p2_d;
      sgn_p2_q    <= sgn_p2_d;
      rnd_p3_q    <= rnd_p3_d;
      maxexp_p3_q <= maxexp_p3_d;
      rsgn_p3_q   <= rsgn_p3_d;
      mag_p3_q    <= mag_p3_d;
      rnd_p4_q    <= rnd_p4_d;
      rsgn_p4_q   <= rsgn_p4_d;
      zero_p4_q   <= zero_p4_d;
      norm_p4_q   <= norm_p4_d;
      exp_p4_q    <= exp_p4_d;
    end
  end

endmodule
